rot_sel_fsm: RTL and testbench
==============================

ROT_SEL_FSM -- requirements
Module: rot_sel_fsm

Interface
REQ-001 Parameter WIDTH, default 2, bit width of each data channel and of the outputs.
REQ-002 Parameter NCH, default 2, number of selectable channels; legal range 2..16.
REQ-003 Derived constant PW = clog2(NCH), pointer width (minimum 1).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port ch_in  input  NCH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port en  input  1  advance enable; when 0, pointer holds.
REQ-008 Port d  input  1  advance request, qualified by en.
REQ-009 Port dir  input  1  direction: 0 = increment pointer, 1 = decrement pointer.
REQ-010 Port load  input  1  synchronous pointer load strobe.
REQ-011 Port load_ptr  input  PW  pointer value applied on load.
REQ-012 Port x_var  output  WIDTH  combinational (Mealy) selected channel.
REQ-013 Port x_q  output  WIDTH  x_var registered one cycle.
REQ-014 Port ptr_q  output  PW  current state pointer.
REQ-015 Port wrap  output  1  one-cycle pulse on pointer wrap-around.
REQ-016 Port err  output  1  one-cycle pulse on illegal load_ptr.

Function
REQ-017 State is pointer ptr in 0..NCH-1; adv = en & d; nxt = ptr+1 (NCH-1 wraps to 0) when dir=0, ptr-1 (0 wraps to NCH-1) when dir=1.
REQ-018 x_var SHALL be ch[ptr] when adv=0 and ch[nxt] when adv=1, same cycle, no register (with NCH=2, dir=0 this is the 2-state A/B toggle selector).
REQ-019 Next ptr priority: load (highest) -> load_ptr; else adv -> nxt; else hold.
REQ-020 load with load_ptr >= NCH SHALL load 0 and pulse err in the following cycle; load_ptr < NCH SHALL not pulse err.
REQ-021 load and adv in the same cycle: load wins, no wrap pulse; x_var still shows ch[nxt] that cycle.
REQ-022 wrap SHALL pulse for one cycle after an adv-driven transition NCH-1->0 (dir=0) or 0->NCH-1 (dir=1); never on load.
REQ-023 x_q SHALL equal the x_var value sampled at the previous rising edge (latency 1).
REQ-024 Changes on dir or d with en=0 SHALL not alter ptr_q; x_var then shows ch[ptr].

Reset
REQ-025 reset low SHALL asynchronously force ptr_q=0, x_q=0, wrap=0, err=0.
REQ-026 While reset low, x_var SHALL be forced to 0 regardless of inputs.
REQ-027 Reset asserted mid-operation SHALL abandon any pending load or advance; first edge after release uses normal priority rules.

Structure
REQ-028 Shared package rot_sel_pkg SHALL hold default WIDTH/NCH, clog2-based PW function and direction constants DIR_UP=0, DIR_DN=1.
REQ-029 Pointer next-state/wrap logic SHALL be a sub-module rot_ptr_ctr (parameter NCH; inputs adv, dir, load, load_ptr; outputs ptr, nxt, wrap, err); output mux and x_q register stay in rot_sel_fsm.

Verification (WIDTH=4, NCH=4, ch0=A, ch1=B, ch2=C, ch3=D hex)
REQ-030 reset low, d=1, en=1 -> x_var=0, x_q=0, ptr_q=0; release, en=1 d=1 dir=0 -> x_var=B same cycle, ptr_q=1 next edge, x_q=B.
REQ-031 en=1 d=1 dir=0 for 4 edges from ptr 0 -> ptr_q 1,2,3,0; wrap high only the cycle after 3->0.
REQ-032 from ptr 0, dir=1 adv -> x_var=D, ptr_q=3, wrap pulses once.
REQ-033 ptr 1, load=1 load_ptr=3 with adv=1 -> ptr_q=3, no wrap, no err; load_ptr=5 (PW=2 -> use NCH=3 bench, load_ptr=3) -> ptr_q=0, err one cycle.
REQ-034 en=0, d toggling, dir toggling for 5 cycles -> ptr_q constant, x_var = ch[ptr_q].
REQ-035 NCH=2, WIDTH=2, a=01 b=10, dir=0: state 0 d=0 -> 01, d=1 -> 10; state 1 d=0 -> 10, d=1 -> 01.

Source files
------------

// File: rtl/rot_sel_pkg.sv
// Shared constants and helpers for the rotating channel selector.
package rot_sel_pkg;

    localparam int unsigned DEF_WIDTH = 2;
    localparam int unsigned DEF_NCH   = 2;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Pointer width for n channels, never narrower than one bit.
    function automatic int unsigned pw_of(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/rot_ptr_ctr.sv
// Wrapping up/down channel pointer with load, wrap and illegal-load flags.
module rot_ptr_ctr
    import rot_sel_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH,
    localparam int unsigned PW = pw_of(NCH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic          dir,
    input  logic          load,
    input  logic [PW-1:0] load_ptr,
    output logic [PW-1:0] ptr,
    output logic [PW-1:0] nxt,
    output logic          wrap,
    output logic          err
);

    localparam logic [PW-1:0] LAST = PW'(NCH - 1);

    logic [PW-1:0] ptr_d;
    logic          wrap_d;
    logic          err_d;
    logic          bad_ptr;

    // A full power-of-two pointer range cannot hold an illegal value.
    generate
        if (NCH == (32'd1 << PW)) begin : g_pow2
            assign bad_ptr = 1'b0;
        end else begin : g_npow2
            assign bad_ptr = (load_ptr >= PW'(NCH));
        end
    endgenerate

    always_comb begin
        nxt = ptr;
        if (dir == DIR_UP) begin
            nxt = (ptr == LAST) ? '0 : ptr + PW'(1);
        end else begin
            nxt = (ptr == '0) ? LAST : ptr - PW'(1);
        end
    end

    // Load outranks advance and never reports a wrap.
    always_comb begin
        ptr_d  = ptr;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            ptr_d = bad_ptr ? '0 : load_ptr;
            err_d = bad_ptr;
        end else if (adv) begin
            ptr_d  = nxt;
            wrap_d = (dir == DIR_UP) ? (ptr == LAST) : (ptr == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr  <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            ptr  <= ptr_d;
            wrap <= wrap_d;
            err  <= err_d;
        end
    end

endmodule

// File: rtl/rot_sel_fsm.sv
// Rotating channel selector: Mealy look-ahead mux plus registered copy.
module rot_sel_fsm
    import rot_sel_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH,
    localparam int unsigned PW   = pw_of(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] ch_in,
    input  logic                 en,
    input  logic                 d,
    input  logic                 dir,
    input  logic                 load,
    input  logic [PW-1:0]        load_ptr,
    output logic [WIDTH-1:0]     x_var,
    output logic [WIDTH-1:0]     x_q,
    output logic [PW-1:0]        ptr_q,
    output logic                 wrap,
    output logic                 err
);

    logic             adv;
    logic [PW-1:0]    nxt;
    logic [PW-1:0]    sel;
    logic [WIDTH-1:0] ch [NCH];

    assign adv = en & d;

    generate
        for (genvar k = 0; k < int'(NCH); k++) begin : g_unpack
            assign ch[k] = ch_in[k*WIDTH +: WIDTH];
        end
    endgenerate

    rot_ptr_ctr #(
        .NCH (NCH)
    ) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .adv      (adv),
        .dir      (dir),
        .load     (load),
        .load_ptr (load_ptr),
        .ptr      (ptr_q),
        .nxt      (nxt),
        .wrap     (wrap),
        .err      (err)
    );

    // Show the channel being advanced to in the same cycle; blank during reset.
    always_comb begin
        sel   = adv ? nxt : ptr_q;
        x_var = reset ? ch[sel] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
        end else begin
            x_q <= x_var;
        end
    end

endmodule

// File: tb/tb_rot_sel_fsm.sv
// Directed bench for rot_sel_fsm: 4-channel, 3-channel and 2-channel instances.
module tb_rot_sel_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // NCH=4, WIDTH=4
    logic [15:0] a_ch;
    logic        a_en, a_d, a_dir, a_load;
    logic [1:0]  a_lp;
    logic [3:0]  a_x, a_xq;
    logic [1:0]  a_ptr;
    logic        a_wrap, a_err;

    // NCH=3, WIDTH=4
    logic [11:0] b_ch;
    logic        b_en, b_d, b_dir, b_load;
    logic [1:0]  b_lp;
    logic [3:0]  b_x, b_xq;
    logic [1:0]  b_ptr;
    logic        b_wrap, b_err;

    // NCH=2, WIDTH=2
    logic [3:0]  c_ch;
    logic        c_en, c_d, c_dir, c_load;
    logic [0:0]  c_lp;
    logic [1:0]  c_x, c_xq;
    logic [0:0]  c_ptr;
    logic        c_wrap, c_err;

    rot_sel_fsm #(.WIDTH(4), .NCH(4)) dut_a (
        .clk(clk), .reset(reset), .ch_in(a_ch), .en(a_en), .d(a_d), .dir(a_dir),
        .load(a_load), .load_ptr(a_lp), .x_var(a_x), .x_q(a_xq), .ptr_q(a_ptr),
        .wrap(a_wrap), .err(a_err)
    );

    rot_sel_fsm #(.WIDTH(4), .NCH(3)) dut_b (
        .clk(clk), .reset(reset), .ch_in(b_ch), .en(b_en), .d(b_d), .dir(b_dir),
        .load(b_load), .load_ptr(b_lp), .x_var(b_x), .x_q(b_xq), .ptr_q(b_ptr),
        .wrap(b_wrap), .err(b_err)
    );

    rot_sel_fsm #(.WIDTH(2), .NCH(2)) dut_c (
        .clk(clk), .reset(reset), .ch_in(c_ch), .en(c_en), .d(c_d), .dir(c_dir),
        .load(c_load), .load_ptr(c_lp), .x_var(c_x), .x_q(c_xq), .ptr_q(c_ptr),
        .wrap(c_wrap), .err(c_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_ch = {4'hD, 4'hC, 4'hB, 4'hA};
        b_ch = {4'hC, 4'hB, 4'hA};
        c_ch = {2'b10, 2'b01};
        {a_en, a_d, a_dir, a_load, a_lp} = '0;
        {b_en, b_d, b_dir, b_load, b_lp} = '0;
        {c_en, c_d, c_dir, c_load, c_lp} = '0;

        // Reset with an advance request pending
        reset = 1'b0;
        a_en = 1'b1; a_d = 1'b1;
        tick(); tick();
        check("rst_x_var", a_x, 4'h0);
        check("rst_x_q",   a_xq, 4'h0);
        check("rst_ptr",   a_ptr, 2'd0);
        check("rst_wrap",  a_wrap, 1'b0);
        check("rst_err",   a_err, 1'b0);

        // Release and count up through a wrap
        reset = 1'b1;
        #1;
        check("up_x_var_b", a_x, 4'hB);
        tick();
        check("up_ptr1", a_ptr, 2'd1);
        check("up_xq_b", a_xq, 4'hB);
        check("up_x_var_c", a_x, 4'hC);
        tick();
        check("up_ptr2", a_ptr, 2'd2);
        check("up_wrap2", a_wrap, 1'b0);
        tick();
        check("up_ptr3", a_ptr, 2'd3);
        check("up_xq_d", a_xq, 4'hD);
        check("up_x_var_a", a_x, 4'hA);
        tick();
        check("up_ptr0", a_ptr, 2'd0);
        check("up_wrap", a_wrap, 1'b1);
        check("up_xq_a", a_xq, 4'hA);
        a_d = 1'b0;
        tick();
        check("hold_ptr0", a_ptr, 2'd0);
        check("up_wrap_gone", a_wrap, 1'b0);

        // Count down from 0 wraps to 3
        a_dir = 1'b1; a_d = 1'b1;
        #1;
        check("dn_x_var_d", a_x, 4'hD);
        tick();
        check("dn_ptr3", a_ptr, 2'd3);
        check("dn_wrap", a_wrap, 1'b1);
        a_d = 1'b0;
        tick();
        check("dn_wrap_gone", a_wrap, 1'b0);
        check("dn_hold3", a_ptr, 2'd3);

        // Load beats advance; no wrap even when the advance would have wrapped
        a_load = 1'b1; a_lp = 2'd1;
        tick();
        check("ld_ptr1", a_ptr, 2'd1);
        a_lp = 2'd3; a_d = 1'b1; a_dir = 1'b0;
        #1;
        check("ld_x_var_nxt", a_x, 4'hC);
        tick();
        check("ld_ptr3", a_ptr, 2'd3);
        check("ld_nowrap", a_wrap, 1'b0);
        check("ld_noerr", a_err, 1'b0);
        a_lp = 2'd2;
        tick();
        check("ld_over_wrap_ptr", a_ptr, 2'd2);
        check("ld_over_wrap_nowrap", a_wrap, 1'b0);
        a_load = 1'b0; a_d = 1'b0;

        // Disabled: d/dir toggling must not move the pointer
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_d = ~a_d; a_dir = ~a_dir;
            #1;
            check("en0_x_var", a_x, 4'hC);
            tick();
            check("en0_ptr", a_ptr, 2'd2);
        end

        // Mid-cycle reset abandons a pending load
        a_en = 1'b1; a_d = 1'b1; a_load = 1'b1; a_lp = 2'd1;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ptr", a_ptr, 2'd0);
        check("midrst_x_var", a_x, 4'h0);
        check("midrst_x_q", a_xq, 4'h0);
        tick();
        a_load = 1'b0; a_dir = 1'b0;
        reset = 1'b1;
        #1;
        check("postrst_x_var", a_x, 4'hB);
        tick();
        check("postrst_ptr", a_ptr, 2'd1);

        // NCH=3: illegal load forces 0 and flags err for one cycle
        b_load = 1'b1; b_lp = 2'd2;
        tick();
        check("b_ld2_ptr", b_ptr, 2'd2);
        check("b_ld2_noerr", b_err, 1'b0);
        b_lp = 2'd3;
        tick();
        check("b_bad_ptr", b_ptr, 2'd0);
        check("b_bad_err", b_err, 1'b1);
        b_load = 1'b0;
        tick();
        check("b_err_gone", b_err, 1'b0);
        b_load = 1'b1; b_lp = 2'd2;
        tick();
        b_load = 1'b0; b_en = 1'b1; b_d = 1'b1; b_dir = 1'b0;
        #1;
        check("b_wrap_x_var", b_x, 4'hA);
        tick();
        check("b_wrap_ptr", b_ptr, 2'd0);
        check("b_wrap", b_wrap, 1'b1);
        check("b_wrap_noerr", b_err, 1'b0);
        b_en = 1'b0;

        // NCH=2 toggle selector
        c_en = 1'b1; c_d = 1'b0;
        #1;
        check("c_s0_d0", c_x, 2'b01);
        c_d = 1'b1;
        #1;
        check("c_s0_d1", c_x, 2'b10);
        tick();
        check("c_ptr1", c_ptr, 1'b1);
        c_d = 1'b0;
        #1;
        check("c_s1_d0", c_x, 2'b10);
        c_d = 1'b1;
        #1;
        check("c_s1_d1", c_x, 2'b01);
        tick();
        check("c_ptr0", c_ptr, 1'b0);
        check("c_wrap", c_wrap, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
